jam_cost_table: RTL and testbench
=================================

Name: jam_cost_table

Overview:
- Upstream stage of the job-assignment search engine. Owns the 8x8 worker/job cost matrix.
- Loads the matrix through a valid/ready stream, then serves combinational Cost lookups on the engine's W/J address.
- Holds the engine in reset until the table is complete, and re-arms it on reload.

Parameters:
- N_SIDE, 8, workers = jobs per side; the address is log2(N_SIDE)=3 bits each. Only 8 is supported.
- COST_W, 7, width of one cost entry.
- SUM_W, 10, width of the optional lower-bound sum. Must satisfy N_SIDE*(2^COST_W-1) <= 2^SUM_W-1.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- in_valid  in  1  load stream: entry present
- in_data  in  7  load stream: cost entry, row-major (W outer, J inner)
- in_ready  out  1  load stream: block accepts an entry
- reload  in  1  one-cycle pulse: discard the table and restart loading
- W  in  3  lookup worker index, from the engine
- J  in  3  lookup job index, from the engine
- Cost  out  7  cost[W][J], combinational
- table_ready  out  1  all 64 entries loaded
- jam_rst  out  1  reset to the engine, registered, active-high
- load_count  out  7  number of entries accepted so far (0..64)

Behaviour:
- Storage: 64 x 7-bit register array; no reset on the array contents.
- Write address of the k-th accepted entry (k=0..63): {W=k[5:3], J=k[2:0]}.
- States:
  - IDLE: entered on reset. Always moves to LOAD on the next cycle.
  - LOAD: in_ready=1. A fire is in_valid&in_ready. Each fire writes mem[load_count] and increments load_count. The fire that makes load_count=64 moves the FSM to READY on the same edge.
  - READY: in_ready=0. in_valid is ignored.
- Registered outputs at the LOAD->READY edge:
  - table_ready 0->1.
  - jam_rst 1->0. The engine leaves reset on the first cycle table_ready=1.
- Reload in READY: next edge goes to LOAD; load_count=0, table_ready=0, jam_rst=1. Array contents are kept but overwritten by the new load.
- Reload in LOAD: load_count is cleared to 0 and the state stays LOAD. If a fire occurs in the same cycle, reload wins and the entry is dropped.
- Reload in IDLE: ignored.
- Cost output:
  - table_ready=1: Cost = mem[{W,J}], zero latency; the engine accumulates it in the same cycle.
  - table_ready=0: Cost = 0.
- Reset values:
  - in_ready=0, table_ready=0, jam_rst=1, load_count=0, Cost=0, state=IDLE.
  - lower_bound=0 when the optional feature is present.
- Reset mid-load: all progress is lost; the sequence restarts from IDLE.
- in_data is sampled only on a fire. There is no backpressure stall inside LOAD: in_ready is held at 1 for the whole state.
- load_count saturates at 64 in READY.

Optional Feature:
- Macro: JAM_COST_LOWER_BOUND_EN.
- Defined:
  - Adds output lower_bound [SUM_W-1:0]: the sum over rows of the minimum entry in each row.
  - Computed incrementally during LOAD. A running row-minimum register is seeded with the first entry of each row (J=0). At the J=7 fire, the row minimum (including that entry) is added to an accumulator.
  - lower_bound is registered, valid when table_ready=1, and reads 0 otherwise.
  - Cleared on reload and on reset.
- Undefined: no lower_bound port, no extra logic.

Test Plan:
- Reset, then 64 back-to-back fires with data=k%100 -> table_ready=1 and jam_rst=0 on the edge after fire 63; load_count=64; W=5,J=3 gives Cost=43.
- Load with in_valid toggled every other cycle -> exactly 64 entries accepted; table_ready rises one edge after the 64th fire; no entry is duplicated or skipped.
- During LOAD, assert reload together with fire at count 20 -> load_count=0, that entry dropped; reload all 64 with value 7 -> every Cost=7.
- In READY, pulse reload -> next cycle table_ready=0, jam_rst=1, Cost=0, in_ready=1. After a fresh load, the new values are read back.
- Assert RST at count 30 -> all outputs return to their reset values immediately; IDLE lasts one cycle, then LOAD with in_ready=1.
- With JAM_COST_LOWER_BOUND_EN: row r entries {r+10,...} with min r+3 -> lower_bound = sum(r+3) over r=0..7 = 52. With all entries 127 -> lower_bound=1016, no overflow.

Source files
------------

// File: rtl/jam_cost_table.sv
// jam_cost_table: 8x8 cost matrix loaded over a valid/ready stream, combinational lookup, engine reset control.
// Define JAM_COST_LOWER_BOUND_EN to add the lower_bound output (sum of row minima).
module jam_cost_table #(
    parameter int N_SIDE = 8,
    parameter int COST_W = 7
`ifdef JAM_COST_LOWER_BOUND_EN
    , parameter int SUM_W = 10
`endif
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      in_valid,
    input  logic [COST_W-1:0]         in_data,
    output logic                      in_ready,
    input  logic                      reload,
    input  logic [$clog2(N_SIDE)-1:0] W,
    input  logic [$clog2(N_SIDE)-1:0] J,
    output logic [COST_W-1:0]         Cost,
    output logic                      table_ready,
    output logic                      jam_rst,
`ifdef JAM_COST_LOWER_BOUND_EN
    output logic [SUM_W-1:0]          lower_bound,
`endif
    output logic [$clog2(N_SIDE*N_SIDE):0] load_count
);
    localparam int AW = $clog2(N_SIDE);
    localparam int NE = N_SIDE * N_SIDE;
    localparam int CW = $clog2(NE) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   load_count_q, load_count_d;
    logic            table_ready_q, table_ready_d;
    logic            jam_rst_q, jam_rst_d;
    logic [COST_W-1:0] mem [NE];
    logic            fire, wr;

    assign in_ready    = state_q == LOAD;
    assign fire        = in_valid & in_ready;
    // A reload in the same cycle as a fire drops the entry.
    assign wr          = fire & ~reload;
    assign table_ready = table_ready_q;
    assign jam_rst     = jam_rst_q;
    assign load_count  = load_count_q;
    assign Cost        = table_ready_q ? mem[{W, J}] : '0;

    always_comb begin
        state_d      = state_q;
        load_count_d = load_count_q;
        case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
                if (reload) begin
                    load_count_d = '0;
                end else if (fire) begin
                    load_count_d = load_count_q + 1'b1;
                    if (load_count_q == CW'(NE - 1)) state_d = READY;
                end
            end
            READY: begin
                if (reload) begin
                    state_d      = LOAD;
                    load_count_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        table_ready_d = state_d == READY;
        jam_rst_d     = ~table_ready_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= IDLE;
            load_count_q  <= '0;
            table_ready_q <= 1'b0;
            jam_rst_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            load_count_q  <= load_count_d;
            table_ready_q <= table_ready_d;
            jam_rst_q     <= jam_rst_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr) mem[load_count_q[CW-2:0]] <= in_data;
    end

`ifdef JAM_COST_LOWER_BOUND_EN
    logic [COST_W-1:0] row_min_q, row_min_d, cur_min;
    logic [SUM_W-1:0]  acc_q, acc_d;

    // Row minimum is reseeded by the J=0 entry and folded into the sum on J=N_SIDE-1.
    always_comb begin
        cur_min   = (load_count_q[AW-1:0] == '0 || in_data < row_min_q) ? in_data : row_min_q;
        row_min_d = wr ? cur_min : row_min_q;
        acc_d     = reload ? '0 : (wr && &load_count_q[AW-1:0]) ? acc_q + SUM_W'(cur_min) : acc_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            row_min_q <= '0;
            acc_q     <= '0;
        end else begin
            row_min_q <= row_min_d;
            acc_q     <= acc_d;
        end
    end

    assign lower_bound = table_ready_q ? acc_q : '0;
`endif
endmodule

// File: tb/tb_jam_cost_table.sv
// tb_jam_cost_table: directed bench for jam_cost_table with a scoreboard of expected Cost readbacks.
module tb_jam_cost_table;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       in_valid = 1'b0;
    logic [6:0] in_data = '0;
    logic       reload = 1'b0;
    logic [2:0] W = '0;
    logic [2:0] J = '0;
    logic       in_ready, table_ready, jam_rst;
    logic [6:0] Cost, load_count;
`ifdef JAM_COST_LOWER_BOUND_EN
    logic [9:0] lower_bound;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [6:0]  model[64];

    jam_cost_table dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .reload(reload), .W(W), .J(J), .Cost(Cost), .table_ready(table_ready), .jam_rst(jam_rst),
`ifdef JAM_COST_LOWER_BOUND_EN
        .lower_bound(lower_bound),
`endif
        .load_count(load_count)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_range(input int lo, input int hi, input bit toggle);
        for (int k = lo; k < hi; k++) begin
            if (toggle) begin
                in_valid = 1'b0;
                in_data  = 7'h55;
                step();
            end
            in_valid = 1'b1;
            in_data  = model[k];
            exp_q.push_back({25'b0, model[k]});
            step();
            if (toggle) chk("count_toggle", {25'b0, load_count}, k + 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic readback(input string tag);
        for (int w = 0; w < 8; w++) begin
            for (int j = 0; j < 8; j++) begin
                W = w[2:0];
                J = j[2:0];
                #1;
                if (exp_q.size() == 0) chk({tag, "_queue"}, 0, 1);
                else chk(tag, {25'b0, Cost}, exp_q.pop_front());
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 0);
        chk({tag, "_table_ready"}, {31'b0, table_ready}, 0);
        chk({tag, "_jam_rst"}, {31'b0, jam_rst}, 1);
        chk({tag, "_load_count"}, {25'b0, load_count}, 0);
        chk({tag, "_cost"}, {25'b0, Cost}, 0);
    endtask

    task automatic reload_pulse();
        reload = 1'b1;
        step();
        reload = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        W = 3'd5;
        J = 3'd3;
        #12;
        chk_reset_outputs("rst");
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("idle_in_ready", {31'b0, in_ready}, 0);
        step();
        chk("load_in_ready", {31'b0, in_ready}, 1);

        for (int k = 0; k < 64; k++) model[k] = 7'(k % 100);
        load_range(0, 63, 0);
        chk("pre_last_table_ready", {31'b0, table_ready}, 0);
        chk("pre_last_jam_rst", {31'b0, jam_rst}, 1);
        chk("pre_last_count", {25'b0, load_count}, 63);
        load_range(63, 64, 0);
        chk("ready_table_ready", {31'b0, table_ready}, 1);
        chk("ready_jam_rst", {31'b0, jam_rst}, 0);
        chk("ready_count", {25'b0, load_count}, 64);
        chk("ready_in_ready", {31'b0, in_ready}, 0);
        W = 3'd5;
        J = 3'd3;
        #1;
        chk("cost_w5_j3", {25'b0, Cost}, 43);
        readback("cost_seq");

        in_valid = 1'b1;
        in_data  = 7'd99;
        repeat (3) step();
        in_valid = 1'b0;
        chk("ready_ignore_count", {25'b0, load_count}, 64);
        W = 3'd1;
        J = 3'd1;
        #1;
        chk("ready_ignore_cost", {25'b0, Cost}, 9);

        reload_pulse();
        chk("reload_table_ready", {31'b0, table_ready}, 0);
        chk("reload_jam_rst", {31'b0, jam_rst}, 1);
        chk("reload_cost", {25'b0, Cost}, 0);
        chk("reload_in_ready", {31'b0, in_ready}, 1);
        chk("reload_count", {25'b0, load_count}, 0);

        for (int k = 0; k < 64; k++) model[k] = 7'((k * 5 + 3) % 128);
        load_range(0, 64, 1);
        chk("toggle_table_ready", {31'b0, table_ready}, 1);
        chk("toggle_count", {25'b0, load_count}, 64);
        readback("cost_toggle");

        reload_pulse();
        for (int k = 0; k < 64; k++) model[k] = 7'd7;
        load_range(0, 20, 0);
        chk("count_20", {25'b0, load_count}, 20);
        in_valid = 1'b1;
        in_data  = 7'd99;
        reload   = 1'b1;
        step();
        reload   = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        chk("reload_fire_count", {25'b0, load_count}, 0);
        chk("reload_fire_in_ready", {31'b0, in_ready}, 1);
        chk("reload_fire_table_ready", {31'b0, table_ready}, 0);
        load_range(0, 64, 0);
        chk("seven_table_ready", {31'b0, table_ready}, 1);
        readback("cost_seven");

        reload_pulse();
        load_range(0, 30, 0);
        chk("count_30", {25'b0, load_count}, 30);
        RST = 1'b1;
        #1;
        exp_q.delete();
        chk_reset_outputs("midrst");
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("midrst_idle_in_ready", {31'b0, in_ready}, 0);
        step();
        chk("midrst_load_in_ready", {31'b0, in_ready}, 1);
        chk("midrst_load_count", {25'b0, load_count}, 0);

`ifdef JAM_COST_LOWER_BOUND_EN
        begin
            int lb;
            chk("lb_loading", {22'b0, lower_bound}, 0);
            for (int r = 0; r < 8; r++)
                for (int j = 0; j < 8; j++)
                    model[r*8+j] = (j == r) ? 7'(r + 3) : 7'(r + 10 + j);
            lb = 0;
            for (int r = 0; r < 8; r++) begin
                int m;
                m = 127;
                for (int j = 0; j < 8; j++) if (int'(model[r*8+j]) < m) m = int'(model[r*8+j]);
                lb += m;
            end
            load_range(0, 64, 0);
            chk("lb_rows", {22'b0, lower_bound}, 52);
            chk("lb_model", {22'b0, lower_bound}, lb);
            reload_pulse();
            chk("lb_reload", {22'b0, lower_bound}, 0);
            for (int k = 0; k < 64; k++) model[k] = 7'd127;
            load_range(0, 64, 0);
            chk("lb_max", {22'b0, lower_bound}, 1016);
            exp_q.delete();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
